pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the MultDiv datapath. A WIDTH-bit operation is split into WIDTH/SLICE lookahead slices, one slice per pipeline stage, with the inter-slice carry registered between stages. One operation is accepted per cycle, and results emerge in order after a fixed latency. A single global stall provides valid/ready backpressure. Each result carries carry-out, signed-overflow and zero flags for the multiplier and divider control logic.

---
 rtl/mult_div_pkg.sv | 22 ++
 rtl/cla_slice.sv | 56 +++++
 rtl/pipelined_cla_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the MultDiv datapath: legal lookahead slice widths,
// stage-count derivation and the result flag bundle.
package mult_div_pkg;

  localparam int SLICE_NARROW = 4;
  localparam int SLICE_WIDE   = 8;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

  function automatic bit slice_is_legal(input int slice);
    return (slice == SLICE_NARROW) || (slice == SLICE_WIDE);
  endfunction

  function automatic int num_stages(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE-bit carry-lookahead block: every internal carry is a flat sum of
// generate/propagate products, so no carry ripples bit to bit.
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             grp_p,
  output logic             grp_g,
  output logic             c_msb
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic             prod;
  logic             gprod;
  logic             g_acc;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] = (p[i-1..0] & cin) | OR_j (g[j] & p[i-1..j+1])
  always_comb begin
    c    = '0;
    prod = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      prod = cin;
      for (int j = 0; j < i; j++) prod = prod & p[j];
      c[i] = prod;
      for (int j = 0; j < i; j++) begin
        prod = g[j];
        for (int k = j + 1; k < i; k++) prod = prod & p[k];
        c[i] = c[i] | prod;
      end
    end
  end

  always_comb begin
    g_acc = 1'b0;
    gprod = 1'b0;
    for (int j = 0; j < SLICE; j++) begin
      gprod = g[j];
      for (int k = j + 1; k < SLICE; k++) gprod = gprod & p[k];
      g_acc = g_acc | gprod;
    end
  end

  assign sum   = p ^ c[SLICE-1:0];
  assign grp_p = &p;
  assign grp_g = g_acc;
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead slice per stage, inter-slice carry
// registered, operands skewed alongside; a single global stall gives backpressure.
module pipelined_cla_adder
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             data_cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N = num_stages(WIDTH, SLICE);

  if (!slice_is_legal(SLICE)) begin : g_bad_slice
    $error("pipelined_cla_adder: SLICE must be 4 or 8");
  end
  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of SLICE");
  end

  // Level k feeds stage k; level 0 is the acceptance register.
  logic             vld_q [N];
  logic             cy_q  [N];
  logic [WIDTH-1:0] a_q   [N];
  logic [WIDTH-1:0] b_q   [N];
  logic [WIDTH-1:0] res_q [N];

  logic [SLICE-1:0] sl_sum  [N];
  logic             sl_p    [N];
  logic             sl_g    [N];
  logic             sl_cmsb [N];
  logic             sl_co   [N];
  logic [WIDTH-1:0] res_d   [N];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  flags_t           flags_q;
  logic             advance;

  assign advance = !out_valid_q || out_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_q[gi][SLICE*gi +: SLICE]),
      .b     (b_q[gi][SLICE*gi +: SLICE]),
      .cin   (cy_q[gi]),
      .sum   (sl_sum[gi]),
      .grp_p (sl_p[gi]),
      .grp_g (sl_g[gi]),
      .c_msb (sl_cmsb[gi])
    );
    assign sl_co[gi] = sl_g[gi] | (sl_p[gi] & cy_q[gi]);
    // Result bits at and above this slice are still zero, so OR-in is exact.
    assign res_d[gi] = res_q[gi] | (WIDTH'(sl_sum[gi]) << (SLICE * gi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      cy_q[0]  <= sub | data_cin;
      a_q[0]   <= data_operandA;
      b_q[0]   <= sub ? ~data_operandB : data_operandB;
      res_q[0] <= '0;
      for (int k = 1; k < N; k++) begin
        vld_q[k] <= vld_q[k-1];
        cy_q[k]  <= sl_co[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        res_q[k] <= res_d[k-1];
      end
      out_valid_q <= vld_q[N-1];
      // Hold the last result across bubbles so idle outputs stay clean.
      if (vld_q[N-1]) begin
        sum_q            <= res_d[N-1];
        flags_q.cout     <= sl_co[N-1];
        flags_q.overflow <= sl_co[N-1] ^ sl_cmsb[N-1];
        flags_q.zero     <= (res_d[N-1] == '0);
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

endmodule
